apb_timer8: RTL and testbench
=============================

Name: apb_timer8

Overview:
- 8-bit programmable up/down timer with an APB slave register interface; a CPU model drives it as a memory-mapped peripheral.
- Counts ticks of an internal clock derived from pclk by a selectable prescaler (/2, /4, /8, /16).
- Sets sticky overflow/underflow flags that software clears by writing 0.

Parameters:
- ADDR_W, 8, APB address width.
- RST_TDR, 8'h00, reset value of TDR.

Ports:
- pclk  in  1  system clock; all logic on rising edge.
- presetn  in  1  synchronous active-low reset, sampled on pclk rising edge.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  register address.
- pwdata  in  8  write data.
- prdata  out  8  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error for unmapped address.

Behaviour:
- One clock, pclk; reset is synchronous and active-low (presetn).
- Register map:
  - 0x00 TDR: load value, R/W, reset RST_TDR.
  - 0x01 TCR: R/W, reset 0x00.
  - 0x02 TSR: reset 0x00.
  - 0x03 TCNT: read-only counter, reset 0x00.
- TCR bit fields:
  - [7] load.
  - [5] dir (0 = up, 1 = down).
  - [4] en.
  - [1:0] cks (00 = /2, 01 = /4, 10 = /8, 11 = /16).
  - Other bits are reserved: they read 0 and writes to them are ignored.
- TSR bit fields:
  - [0] ovf.
  - [1] udf.
  - Other bits read 0.
- APB transfers:
  - Zero wait states: pready = 1 whenever psel & penable.
  - A write commits on the pclk edge where psel & penable & pwrite.
  - prdata is driven combinationally from paddr when psel & !pwrite; otherwise prdata = 0.
  - pslverr = 1 in the access phase for addresses above 0x04 (above 0x03 without TIMER_INT_EN); such writes have no effect.
- Prescaler:
  - Free-running 4-bit counter on pclk, cleared by reset.
  - tick = 1-cycle pulse when the selected divider bit has a 1->0 transition:
    - /2: every 2 pclk.
    - /4: every 4 pclk.
    - /8: every 8 pclk.
    - /16: every 16 pclk.
  - The prescaler does not reset on en changes.
- Counter, in priority order:
  - Reset: TCNT = 0.
  - load = 1: TCNT <= TDR every cycle; counting is inhibited.
  - Else en & tick: TCNT <= TCNT + 1 (dir = 0) or TCNT - 1 (dir = 1), mod 256.
  - Else: hold.
- Pause/resume:
  - Clearing en freezes TCNT.
  - Setting en again continues from the held value; no reload occurs.
- Flags:
  - ovf sets when counting up from 0xFF to 0x00.
  - udf sets when counting down from 0x00 to 0xFF.
  - Flags are sticky.
  - A TSR write clears each flag whose written bit is 0; a written 1 leaves the flag unchanged.
  - Flag set and clear in the same cycle: set wins.
- Reading TSR has no side effects.
- Changing cks mid-count takes effect on the next tick; a spurious extra tick of at most one is permitted.
- Reset mid-operation: all registers, flags and the prescaler return to reset values on the next edge.

Optional Feature:
- Macro: TIMER_INT_EN.
- When defined:
  - Adds register TIER at 0x04: [0] ovf_ie, [1] udf_ie, reset 0.
  - Adds output ports tmr_ovf = ovf & ovf_ie and tmr_udf = udf & udf_ie. Both are registered-level outputs that fall when the flag is cleared.
- When undefined:
  - No TIER register and no interrupt ports.
  - Address 0x04 returns pslverr.

Test Plan:
- After reset, read TDR/TCR/TSR/TCNT -> 0x00, 0x00, 0x00, 0x00; pslverr = 0.
- Write TCR = 0x10, wait 256 × 2 pclk -> read TSR = 0x01; then write TSR = 0x00 -> read TSR = 0x00.
- Pause: TCR = 0x10, wait N × 2 pclk (N random 1..255), TCR = 0x00, idle 200 ns, TCR = 0x10, wait (256 − N) × 2 pclk -> TSR = 0x01 (TCNT frozen during pause).
- Down count: TDR = 0x05, TCR = 0x80 then TCR = 0x31 (/4, down, en), wait 6 × 4 pclk -> TSR = 0x02, TCNT = 0xFF.
- Load: TDR = 0xFE, TCR = 0x80, TCR = 0x13 (/16) -> after 2 × 16 pclk, TSR = 0x01 and TCNT = 0x00; write TSR = 0x02 -> ovf cleared.
- Write and read address 0x07 -> pslverr = 1, prdata = 0, no register changes.

Source files
------------

// File: rtl/apb_timer8.sv
// apb_timer8: 8-bit up/down timer with prescaler and APB register access.
// Optional interrupt register/outputs are enabled by defining TIMER_INT_EN.
module apb_timer8 #(
    parameter int          ADDR_W  = 8,
    parameter logic [7:0]  RST_TDR = 8'h00
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr
`ifdef TIMER_INT_EN
    ,
    output logic              tmr_ovf,
    output logic              tmr_udf
`endif
);

`ifdef TIMER_INT_EN
    localparam int LAST_ADDR = 4;
`else
    localparam int LAST_ADDR = 3;
`endif

    logic [7:0] tdr_q, tdr_d;
    logic [7:0] tcr_q, tcr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] presc_q, presc_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;
    logic       access, addr_err, wr;
    logic       sel_tdr, sel_tcr, sel_tsr, sel_cnt, sel_ier;
    logic       tick, ovf_set, udf_set;
`ifdef TIMER_INT_EN
    logic [1:0] ier_q, ier_d;
`endif

    assign access   = psel & penable;
    assign addr_err = paddr > ADDR_W'(LAST_ADDR);
    assign wr       = access & pwrite & ~addr_err;
    assign pready   = access;
    assign pslverr  = access & addr_err;

    assign sel_tdr = paddr == ADDR_W'(0);
    assign sel_tcr = paddr == ADDR_W'(1);
    assign sel_tsr = paddr == ADDR_W'(2);
    assign sel_cnt = paddr == ADDR_W'(3);
`ifdef TIMER_INT_EN
    assign sel_ier = paddr == ADDR_W'(4);
    assign tmr_ovf = ovf_q & ier_q[0];
    assign tmr_udf = udf_q & ier_q[1];
`else
    assign sel_ier = 1'b0;
`endif

    // tick fires on the cycle the selected prescaler bit is about to fall
    always_comb begin
        tick    = 1'b0;
        presc_d = presc_q + 4'd1;
        unique case (tcr_q[1:0])
            2'b00: tick = presc_q[0];
            2'b01: tick = &presc_q[1:0];
            2'b10: tick = &presc_q[2:0];
            2'b11: tick = &presc_q;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (tcr_q[7]) begin
            cnt_d = tdr_q;
        end else if (tcr_q[4] && tick) begin
            if (tcr_q[5]) begin
                cnt_d   = cnt_q - 8'd1;
                udf_set = cnt_q == 8'h00;
            end else begin
                cnt_d   = cnt_q + 8'd1;
                ovf_set = cnt_q == 8'hFF;
            end
        end
    end

    always_comb begin
        tdr_d = tdr_q;
        tcr_d = tcr_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
`ifdef TIMER_INT_EN
        ier_d = ier_q;
        if (wr && sel_ier) ier_d = pwdata[1:0];
`endif
        if (wr && sel_tdr) tdr_d = pwdata;
        if (wr && sel_tcr) tcr_d = pwdata & 8'hB3;
        if (wr && sel_tsr) begin
            ovf_d = ovf_q & pwdata[0];
            udf_d = udf_q & pwdata[1];
        end
        ovf_d = ovf_d | ovf_set;
        udf_d = udf_d | udf_set;
    end

    always_comb begin
        prdata = 8'h00;
        if (psel && !pwrite) begin
            unique case (1'b1)
                sel_tdr: prdata = tdr_q;
                sel_tcr: prdata = tcr_q;
                sel_tsr: prdata = {6'b0, udf_q, ovf_q};
                sel_cnt: prdata = cnt_q;
`ifdef TIMER_INT_EN
                sel_ier: prdata = {6'b0, ier_q};
`endif
                default: prdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tdr_q   <= RST_TDR;
            tcr_q   <= 8'h00;
            cnt_q   <= 8'h00;
            presc_q <= 4'h0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
`ifdef TIMER_INT_EN
            ier_q   <= 2'b00;
`endif
        end else begin
            tdr_q   <= tdr_d;
            tcr_q   <= tcr_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`ifdef TIMER_INT_EN
            ier_q   <= ier_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_timer8.sv
// Randomized scoreboard bench for apb_timer8 against a behavioural model.
// Define TIMER_INT_EN for both files to exercise the interrupt register.
module tb_apb_timer8;

`ifdef TIMER_INT_EN
    localparam int LAST = 4;
`else
    localparam int LAST = 3;
`endif

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
`ifdef TIMER_INT_EN
    logic       tmr_ovf, tmr_udf;
`endif

    apb_timer8 #(.ADDR_W(8), .RST_TDR(8'h00)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
`ifdef TIMER_INT_EN
        , .tmr_ovf(tmr_ovf), .tmr_udf(tmr_udf)
`endif
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [7:0] data;
        logic       err;
        string      name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // behavioural model state (plain integers)
    int m_tdr, m_tcr, m_cnt, m_ovf, m_udf, m_tier, m_pclks;

    initial begin
        m_tdr = 0; m_tcr = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
        m_tier = 0; m_pclks = 0;
        forever begin
            @(posedge pclk);
            if (!presetn) begin
                m_tdr = 0; m_tcr = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
                m_tier = 0; m_pclks = 0;
            end else begin
                int div;
                int setf_o, setf_u;
                div = 2 << (m_tcr % 4);
                setf_o = 0;
                setf_u = 0;
                if (m_tcr >= 128) begin
                    m_cnt = m_tdr;
                end else if ((m_tcr & 8'h10) != 0 && ((m_pclks + 1) % div) == 0) begin
                    if ((m_tcr & 8'h20) != 0) begin
                        if (m_cnt == 0) setf_u = 1;
                        m_cnt = (m_cnt + 255) % 256;
                    end else begin
                        if (m_cnt == 255) setf_o = 1;
                        m_cnt = (m_cnt + 1) % 256;
                    end
                end
                if (psel && penable && pwrite && int'(paddr) <= LAST) begin
                    case (int'(paddr))
                        0: m_tdr = int'(pwdata);
                        1: m_tcr = int'(pwdata) & 8'hB3;
                        2: begin
                            if (!pwdata[0]) m_ovf = 0;
                            if (!pwdata[1]) m_udf = 0;
                        end
                        4: m_tier = int'(pwdata) & 3;
                        default: ;
                    endcase
                end
                if (setf_o != 0) m_ovf = 1;
                if (setf_u != 0) m_udf = 1;
                m_pclks = (m_pclks + 1) % 16;
            end
        end
    end

    function automatic logic [7:0] mread(input int a);
        case (a)
            0: return 8'(m_tdr);
            1: return 8'(m_tcr);
            2: return 8'(m_udf * 2 + m_ovf);
            3: return 8'(m_cnt);
            4: return (LAST == 4) ? 8'(m_tier) : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // monitor: compares each access phase against the queued expectation
    always @(negedge pclk) begin
        if (psel && penable) begin
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_access addr %02h", paddr);
            end else begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (prdata !== e.data) begin
                    errors++;
                    $display("FAIL %s prdata got %02h want %02h",
                             e.name, prdata, e.data);
                end
                checks++;
                if (pslverr !== e.err || pready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s pslverr/pready got %b/%b want %b/1",
                             e.name, pslverr, pready, e.err);
                end
            end
        end
`ifdef TIMER_INT_EN
        checks++;
        if (tmr_ovf !== (m_ovf != 0 && (m_tier & 1) != 0) ||
            tmr_udf !== (m_udf != 0 && (m_tier & 2) != 0)) begin
            errors++;
            $display("FAIL irq got %b%b want ovf %0d udf %0d tier %0d",
                     tmr_ovf, tmr_udf, m_ovf, m_udf, m_tier);
        end
`endif
    end

    task automatic apb(input bit wr, input int a, input int d, input string nm);
        exp_t e;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = 8'(a); pwdata = 8'(d);
        @(posedge pclk); #1;
        penable = 1'b1;
        e.data = wr ? 8'h00 : mread(a);
        e.err  = a > LAST;
        e.name = nm;
        q.push_back(e);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
    endtask

    task automatic do_reset();
        @(posedge pclk); #1;
        presetn = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;

        apb(0, 0, 0, "rst_tdr");
        apb(0, 1, 0, "rst_tcr");
        apb(0, 2, 0, "rst_tsr");
        apb(0, 3, 0, "rst_tcnt");

        apb(1, 1, 8'h10, "up_en");
        idle(512);
        apb(0, 2, 0, "up_ovf");
        apb(1, 2, 8'h00, "tsr_clr");
        apb(0, 2, 0, "tsr_after_clr");

        n = $urandom_range(1, 255);
        apb(1, 1, 8'h10, "pause_en");
        idle(n * 2);
        apb(1, 1, 8'h00, "pause_dis");
        idle(20);
        apb(0, 3, 0, "pause_frozen");
        apb(1, 1, 8'h10, "pause_resume");
        idle((256 - n) * 2);
        apb(0, 2, 0, "pause_tsr");
        apb(0, 3, 0, "pause_tcnt");

        apb(1, 2, 8'h00, "clr_all");
        apb(1, 0, 8'h05, "dn_tdr");
        apb(1, 1, 8'h80, "dn_load");
        apb(1, 1, 8'h31, "dn_en");
        idle(24);
        apb(0, 2, 0, "dn_tsr");
        apb(0, 3, 0, "dn_tcnt");

        apb(1, 2, 8'h00, "clr_all2");
        apb(1, 0, 8'hFE, "ld_tdr");
        apb(1, 1, 8'h80, "ld_load");
        apb(1, 1, 8'h13, "ld_en16");
        idle(32);
        apb(0, 2, 0, "ld_tsr");
        apb(0, 3, 0, "ld_tcnt");
        apb(1, 2, 8'h02, "ld_clr_ovf");
        apb(0, 2, 0, "ld_tsr_after");

        apb(1, 7, 8'h55, "err_wr");
        apb(0, 7, 0, "err_rd");
        apb(1, 4, 8'h03, "addr4_wr");
        apb(0, 4, 0, "addr4_rd");
        for (int a = 0; a < 4; a++) apb(0, a, 0, "post_err");

        for (int i = 0; i < 300; i++) begin
            int a, d;
            bit w;
            if ($urandom_range(0, 29) == 0) begin
                do_reset();
                apb(0, 3, 0, "rnd_rst_tcnt");
            end else begin
                a = $urandom_range(0, 7);
                w = 1'($urandom_range(0, 1));
                d = $urandom_range(0, 255);
                if (a == 1 && $urandom_range(0, 3) != 0) d = d & 8'h7F;
                apb(w, a, d, w ? "rnd_wr" : "rnd_rd");
                idle($urandom_range(0, 40));
            end
        end

        idle(2);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
